bank_htu_set_ctrl: RTL and testbench

Parametrised set controller for the bank hit-test unit. It holds the tag, validity and per-offset coherence state of one cache set with WAYS ways and OFFSETS offsets per line. It serves read/write/flush/invalidate lookups through a valid/ready request port with a registered response. It also runs a set-wide write-back walk that drains every dirty line through a handshaked write-back port without losing the line.

---
 rtl/bank_htu_pkg.sv | 25 ++
 rtl/bank_htu_set_ctrl_if.sv | 56 +++++
 rtl/bank_htu_plru_tree_param.sv | 53 +++++
 rtl/bank_htu_set_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_bank_htu_set_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_htu_pkg.sv
// Shared types for the bank hit-test unit set controller.
// Request opcodes, per-offset coherence states and walk FSM states.
package bank_htu_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_INVAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_INV   = 2'b00,
    ST_CLEAN = 2'b01,
    ST_DIRTY = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SCAN = 2'd1,
    W_WB   = 2'd2,
    W_DONE = 2'd3
  } walk_e;

endpackage

// File: rtl/bank_htu_set_ctrl_if.sv
// Request, response, walk and write-back bundle of the set controller.
// The slave modport is the controller side, master the client side.
interface bank_htu_set_ctrl_if
  import bank_htu_pkg::*;
#(
  parameter int WAYS    = 8,
  parameter int OFFSETS = 2,
  parameter int TAG_W   = 22
);
  localparam int WW = $clog2(WAYS);
  localparam int OW = $clog2(OFFSETS);

  logic               req_valid_i;
  logic               req_ready_o;
  op_e                req_op_i;
  logic [TAG_W-1:0]   req_tag_i;
  logic [OW-1:0]      req_offset_i;

  logic               resp_valid_o;
  logic               resp_hit_o;
  logic [WW-1:0]      resp_way_o;
  logic [2*OFFSETS-1:0] resp_state_o;
  logic               resp_evict_o;
  logic [TAG_W-1:0]   resp_evict_tag_o;

  logic               walk_start_i;
  logic               walk_busy_o;
  logic               walk_done_o;

  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [WW-1:0]      wb_way_o;
  logic [TAG_W-1:0]   wb_tag_o;
  logic [OFFSETS-1:0] wb_dirty_mask_o;

  modport slave (
    input  req_valid_i, req_op_i, req_tag_i,
    input  req_offset_i, walk_start_i, wb_ready_i,
    output req_ready_o, resp_valid_o, resp_hit_o,
    output resp_way_o, resp_state_o, resp_evict_o,
    output resp_evict_tag_o, walk_busy_o, walk_done_o,
    output wb_valid_o, wb_way_o, wb_tag_o,
    output wb_dirty_mask_o
  );

  modport master (
    output req_valid_i, req_op_i, req_tag_i,
    output req_offset_i, walk_start_i, wb_ready_i,
    input  req_ready_o, resp_valid_o, resp_hit_o,
    input  resp_way_o, resp_state_o, resp_evict_o,
    input  resp_evict_tag_o, walk_busy_o, walk_done_o,
    input  wb_valid_o, wb_way_o, wb_tag_o,
    input  wb_dirty_mask_o
  );

endinterface

// File: rtl/bank_htu_plru_tree_param.sv
// Tree pseudo-LRU for one set: WAYS-1 heap-indexed bits, root at 1.
// A bit of 0 points at the lower half; accesses point the path away.
module bank_htu_plru_tree_param #(
  parameter int WAYS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            acc_valid_i,
  input  logic [WAYS-1:0] acc_way_i,
  output logic [WAYS-1:0] victim_o
);
  localparam int LVL = $clog2(WAYS);
  localparam logic [WAYS-1:0] ONE = {{(WAYS-1){1'b0}}, 1'b1};

  logic [WAYS-1:1] bits_q;
  logic [WAYS-1:1] bits_d;
  logic [LVL-1:0]  acc_idx;

  // Encode the accessed way and flip its path to point away from it.
  always_comb begin : encode_next
    int node;
    node = 0;
    acc_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (acc_way_i[w]) acc_idx = acc_idx | LVL'(w);
    end
    bits_d = bits_q;
    for (int l = 0; l < LVL; l++) begin
      node = (1 << l) | int'(acc_idx >> (LVL - l));
      bits_d[node] = ~acc_idx[LVL-1-l];
    end
  end

  // Follow the tree bits from the root down to the victim leaf.
  always_comb begin : follow
    int node;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      node = 2 * node + int'(bits_q[node]);
    end
    victim_o = ONE << (node - WAYS);
  end

  // Commit the path update on a qualifying access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bits_q <= '0;
    end else if (acc_valid_i) begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/bank_htu_set_ctrl.sv
// Set controller: tag/state lookup with registered response and
// a set-wide write-back walk draining dirty lines over a handshake.
module bank_htu_set_ctrl
  import bank_htu_pkg::*;
#(
  parameter int WAYS    = 8,
  parameter int OFFSETS = 2,
  parameter int TAG_W   = 22
) (
  input logic              clk_i,
  input logic              rst_i,
  bank_htu_set_ctrl_if.slave bus
);
  localparam int WW = $clog2(WAYS);
  localparam int LW = 2 * OFFSETS;
  localparam logic [WAYS-1:0] ONE = {{(WAYS-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] LAST = WW'(WAYS - 1);

  logic [TAG_W-1:0]   tag_q  [WAYS];
  logic [LW-1:0]      line_q [WAYS];

  logic [WAYS-1:0]    vld, dty, hitv;
  logic [OFFSETS-1:0] dmask [WAYS];
  logic [WW-1:0]      hit_idx, inv_idx, vic_idx;
  logic [WW-1:0]      alloc_idx, way_sel;
  logic [WAYS-1:0]    vic_oh, acc_oh;
  logic               hit, any_inv, is_rw;
  logic               ready, acc, plru_acc, wb_fire;
  logic [LW-1:0]      cur_line, nxt_line;
  logic               ev;
  logic [TAG_W-1:0]   ev_tag;

  walk_e              wstate;
  logic [WW-1:0]      ptr;
  logic               busy_q, done_q;
  logic               wb_valid_q;
  logic [WW-1:0]      wb_way_q;
  logic [TAG_W-1:0]   wb_tag_q;
  logic [OFFSETS-1:0] wb_mask_q;

  logic               resp_valid_q, resp_hit_q, resp_ev_q;
  logic [WW-1:0]      resp_way_q;
  logic [LW-1:0]      resp_st_q;
  logic [TAG_W-1:0]   resp_ev_tag_q;

  function automatic logic [LW-1:0] clean_line(
    input logic [LW-1:0] l
  );
    logic [LW-1:0] r;
    r = l;
    for (int o = 0; o < OFFSETS; o++) begin
      if (l[2*o+:2] == ST_DIRTY) r[2*o+:2] = ST_CLEAN;
    end
    return r;
  endfunction

  // Per-way validity, dirtiness, tag match and priority encoders.
  always_comb begin : lookup
    vld = '0;
    dty = '0;
    hitv = '0;
    hit_idx = '0;
    inv_idx = '0;
    vic_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      dmask[w] = '0;
      for (int o = 0; o < OFFSETS; o++) begin
        dmask[w][o] = (line_q[w][2*o+:2] == ST_DIRTY);
      end
      vld[w] = |line_q[w];
      dty[w] = |dmask[w];
      hitv[w] = vld[w] && (tag_q[w] == bus.req_tag_i);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w]) inv_idx = WW'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (hitv[w]) hit_idx = hit_idx | WW'(w);
      if (vic_oh[w]) vic_idx = vic_idx | WW'(w);
    end
  end

  assign hit      = |hitv;
  assign any_inv  = ~&vld;
  assign is_rw    = (bus.req_op_i == OP_READ) ||
                    (bus.req_op_i == OP_WRITE);
  assign ready    = (wstate == W_IDLE) & ~bus.walk_start_i;
  assign acc      = bus.req_valid_i & ready;
  assign plru_acc = acc & is_rw;
  assign alloc_idx = any_inv ? inv_idx : vic_idx;
  assign acc_oh   = ONE << way_sel;
  assign wb_fire  = wb_valid_q & bus.wb_ready_i;

  // Selected way: hit way, allocation target, or way 0 otherwise.
  always_comb begin : select
    way_sel = '0;
    if (hit) way_sel = hit_idx;
    else if (is_rw) way_sel = alloc_idx;
  end

  // Post-access line state and eviction report.
  always_comb begin : next_line
    int off;
    off = int'(bus.req_offset_i);
    cur_line = line_q[way_sel];
    nxt_line = cur_line;
    ev = 1'b0;
    ev_tag = '0;
    unique case (1'b1)
      (!hit && is_rw): begin
        nxt_line = '0;
        nxt_line[2*off+:2] = (bus.req_op_i == OP_WRITE) ?
                             ST_DIRTY : ST_CLEAN;
        ev = dty[way_sel];
        ev_tag = dty[way_sel] ? tag_q[way_sel] : '0;
      end
      (hit && bus.req_op_i == OP_READ): begin
        if (cur_line[2*off+:2] == ST_INV)
          nxt_line[2*off+:2] = ST_CLEAN;
      end
      (hit && bus.req_op_i == OP_WRITE): begin
        nxt_line[2*off+:2] = ST_DIRTY;
      end
      (hit && bus.req_op_i == OP_FLUSH): begin
        nxt_line = clean_line(cur_line);
        ev = dty[way_sel];
        ev_tag = dty[way_sel] ? tag_q[way_sel] : '0;
      end
      (hit && bus.req_op_i == OP_INVAL): begin
        nxt_line = '0;
      end
      default: ;
    endcase
  end

  bank_htu_plru_tree_param #(
    .WAYS (WAYS)
  ) u_plru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .acc_valid_i (plru_acc),
    .acc_way_i   (acc_oh),
    .victim_o    (vic_oh)
  );

  // Tag and line state storage; requests and walk never overlap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w]  <= '0;
        line_q[w] <= '0;
      end
    end else if (acc && (hit || is_rw)) begin
      line_q[way_sel] <= nxt_line;
      if (!hit) tag_q[way_sel] <= bus.req_tag_i;
    end else if (wb_fire) begin
      line_q[wb_way_q] <= clean_line(line_q[wb_way_q]);
    end
  end

  // Registered one-cycle response carrying pre-update state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_st_q     <= '0;
      resp_ev_q     <= 1'b0;
      resp_ev_tag_q <= '0;
    end else begin
      resp_valid_q <= acc;
      if (acc) begin
        resp_hit_q    <= hit;
        resp_way_q    <= way_sel;
        resp_st_q     <= cur_line;
        resp_ev_q     <= ev;
        resp_ev_tag_q <= ev_tag;
      end
    end
  end

  // Walk FSM: scan ways, stall on dirty ones until write-back accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate     <= W_IDLE;
      ptr        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_way_q   <= '0;
      wb_tag_q   <= '0;
      wb_mask_q  <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (bus.walk_start_i) begin
            wstate <= W_SCAN;
            ptr    <= '0;
            busy_q <= 1'b1;
          end
        end
        W_SCAN: begin
          if (dty[ptr]) begin
            wstate     <= W_WB;
            wb_valid_q <= 1'b1;
            wb_way_q   <= ptr;
            wb_tag_q   <= tag_q[ptr];
            wb_mask_q  <= dmask[ptr];
          end else if (ptr == LAST) begin
            wstate <= W_DONE;
            done_q <= 1'b1;
          end else begin
            ptr <= ptr + WW'(1);
          end
        end
        W_WB: begin
          if (bus.wb_ready_i) begin
            wb_valid_q <= 1'b0;
            if (ptr == LAST) begin
              wstate <= W_DONE;
              done_q <= 1'b1;
            end else begin
              wstate <= W_SCAN;
              ptr    <= ptr + WW'(1);
            end
          end
        end
        W_DONE: begin
          wstate <= W_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o      = ready;
  assign bus.resp_valid_o     = resp_valid_q;
  assign bus.resp_hit_o       = resp_hit_q;
  assign bus.resp_way_o       = resp_way_q;
  assign bus.resp_state_o     = resp_st_q;
  assign bus.resp_evict_o     = resp_ev_q;
  assign bus.resp_evict_tag_o = resp_ev_tag_q;
  assign bus.walk_busy_o      = busy_q;
  assign bus.walk_done_o      = done_q;
  assign bus.wb_valid_o       = wb_valid_q;
  assign bus.wb_way_o         = wb_way_q;
  assign bus.wb_tag_o         = wb_tag_q;
  assign bus.wb_dirty_mask_o  = wb_mask_q;

endmodule

// File: tb/tb_bank_htu_set_ctrl.sv
// Scoreboard bench for bank_htu_set_ctrl: directed scenarios plus
// random traffic against a behavioural set model.
module tb_bank_htu_set_ctrl;
  import bank_htu_pkg::*;

  localparam int WAYS    = 8;
  localparam int OFFSETS = 2;
  localparam int TAG_W   = 22;

  typedef struct {
    bit hit; int way; int st; bit ev; int etag;
  } rsp_t;
  typedef struct { int way; int tag; int mask; } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bank_htu_set_ctrl_if #(
    .WAYS(WAYS), .OFFSETS(OFFSETS), .TAG_W(TAG_W)
  ) bus ();

  bank_htu_set_ctrl #(
    .WAYS(WAYS), .OFFSETS(OFFSETS), .TAG_W(TAG_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  rsp_t rq[$];
  wb_t  wq[$];
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  int m_tag [WAYS];
  int m_st  [WAYS][OFFSETS];
  bit m_pl  [WAYS];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic void m_reset();
    for (int w = 0; w < WAYS; w++) begin
      m_tag[w] = 0;
      m_pl[w] = 0;
      for (int o = 0; o < OFFSETS; o++) m_st[w][o] = 0;
    end
  endfunction

  function automatic bit m_valid(int w);
    for (int o = 0; o < OFFSETS; o++)
      if (m_st[w][o] != 0) return 1;
    return 0;
  endfunction

  function automatic int m_dmask(int w);
    int m = 0;
    for (int o = 0; o < OFFSETS; o++)
      if (m_st[w][o] == 2) m |= (1 << o);
    return m;
  endfunction

  // Descend by halving the way range; bit set means "go upper".
  function automatic int m_victim();
    int lo = 0, sz = WAYS, n = 1;
    while (sz > 1) begin
      if (m_pl[n]) begin lo += sz / 2; n = 2 * n + 1; end
      else n = 2 * n;
      sz = sz / 2;
    end
    return lo;
  endfunction

  function automatic void m_touch(int w);
    int lo = 0, sz = WAYS, n = 1;
    bit up;
    while (sz > 1) begin
      up = (w >= lo + sz / 2);
      m_pl[n] = !up;
      if (up) lo += sz / 2;
      n = 2 * n + int'(up);
      sz = sz / 2;
    end
  endfunction

  function automatic void m_req(op_e op, int tag, int off);
    rsp_t e;
    int hw = -1;
    bit rw = (op == OP_READ) || (op == OP_WRITE);
    for (int w = 0; w < WAYS; w++)
      if (m_valid(w) && m_tag[w] == tag) hw = w;
    e.hit = (hw >= 0);
    e.ev = 0;
    e.etag = 0;
    e.way = 0;
    if (e.hit) e.way = hw;
    else if (rw) begin
      e.way = -1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid(w)) e.way = w;
      if (e.way < 0) e.way = m_victim();
    end
    e.st = 0;
    for (int o = 0; o < OFFSETS; o++)
      e.st |= m_st[e.way][o] << (2 * o);
    if (!e.hit && rw) begin
      if (m_dmask(e.way) != 0) begin
        e.ev = 1;
        e.etag = m_tag[e.way];
      end
      m_tag[e.way] = tag;
      for (int o = 0; o < OFFSETS; o++) m_st[e.way][o] = 0;
      m_st[e.way][off] = (op == OP_WRITE) ? 2 : 1;
      m_touch(e.way);
    end else if (e.hit) begin
      case (op)
        OP_READ: begin
          if (m_st[hw][off] == 0) m_st[hw][off] = 1;
          m_touch(hw);
        end
        OP_WRITE: begin
          m_st[hw][off] = 2;
          m_touch(hw);
        end
        OP_FLUSH: begin
          if (m_dmask(hw) != 0) begin
            e.ev = 1;
            e.etag = m_tag[hw];
          end
          for (int o = 0; o < OFFSETS; o++)
            if (m_st[hw][o] == 2) m_st[hw][o] = 1;
        end
        default:
          for (int o = 0; o < OFFSETS; o++) m_st[hw][o] = 0;
      endcase
    end
    rq.push_back(e);
  endfunction

  // Expected write-back sequence of a walk; walk also cleans the model.
  function automatic int m_walk();
    wb_t x;
    int nd = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_dmask(w) != 0) begin
        x.way = w;
        x.tag = m_tag[w];
        x.mask = m_dmask(w);
        wq.push_back(x);
        nd++;
        for (int o = 0; o < OFFSETS; o++)
          if (m_st[w][o] == 2) m_st[w][o] = 1;
      end
    end
    return nd;
  endfunction

  always @(negedge clk) begin : mon
    rsp_t e;
    wb_t x;
    if (!rst) begin
      if (bus.resp_valid_o) begin
        if (rq.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("resp_hit", int'(bus.resp_hit_o), int'(e.hit));
          chk("resp_way", int'(bus.resp_way_o), e.way);
          chk("resp_state", int'(bus.resp_state_o), e.st);
          chk("resp_evict", int'(bus.resp_evict_o), int'(e.ev));
          if (e.ev)
            chk("resp_evict_tag", int'(bus.resp_evict_tag_o), e.etag);
        end
      end
      if (bus.wb_valid_o) begin
        if (wq.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          x = wq[0];
          chk("wb_way", int'(bus.wb_way_o), x.way);
          chk("wb_tag", int'(bus.wb_tag_o), x.tag);
          chk("wb_mask", int'(bus.wb_dirty_mask_o), x.mask);
          if (bus.wb_ready_i) void'(wq.pop_front());
        end
      end
      if (bus.walk_done_o) done_cnt++;
    end
  end

  task automatic idle_inputs();
    bus.req_valid_i = 0;
    bus.req_op_i = OP_READ;
    bus.req_tag_i = '0;
    bus.req_offset_i = '0;
    bus.walk_start_i = 0;
    bus.wb_ready_i = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_reset();
    rq.delete();
    wq.delete();
  endtask

  task automatic req(op_e op, int tag, int off);
    int n = 0;
    bus.req_valid_i = 1;
    bus.req_op_i = op;
    bus.req_tag_i = TAG_W'(tag);
    bus.req_offset_i = off[0];
    #0;
    while (!bus.req_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("req_ready_timeout", 0, 1);
    m_req(op, tag, off);
    @(posedge clk); #1;
    bus.req_valid_i = 0;
  endtask

  task automatic run_walk(int stall, bit with_req);
    int nd, d0, cyc, cnt, busy_n, exp_busy;
    nd = m_walk();
    exp_busy = WAYS + 1 + nd * (stall + 1);
    d0 = done_cnt;
    bus.walk_start_i = 1;
    if (with_req) begin
      bus.req_valid_i = 1;
      bus.req_op_i = OP_READ;
      bus.req_tag_i = TAG_W'(99);
    end
    #1;
    chk("walk_start_ready", int'(bus.req_ready_o), with_req ? 0 : 0);
    @(posedge clk); #1;
    bus.walk_start_i = 0;
    bus.req_valid_i = 0;
    cyc = 0; cnt = 0; busy_n = 0;
    while (bus.walk_busy_o && cyc < 400) begin
      busy_n++;
      if (bus.wb_valid_o) begin
        if (cnt >= stall) begin bus.wb_ready_i = 1; cnt = 0; end
        else begin bus.wb_ready_i = 0; cnt++; end
      end else bus.wb_ready_i = 0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.wb_ready_i = 0;
    if (cyc >= 400) chk("walk_timeout", 0, 1);
    chk("walk_cycles", busy_n, exp_busy);
    chk("walk_done_pulses", done_cnt - d0, 1);
    chk("walk_wb_drained", wq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    chk("rst_ready", int'(bus.req_ready_o), 1);
    chk("rst_resp_valid", int'(bus.resp_valid_o), 0);
    chk("rst_busy", int'(bus.walk_busy_o), 0);
    chk("rst_done", int'(bus.walk_done_o), 0);
    chk("rst_wb_valid", int'(bus.wb_valid_o), 0);
    chk("rst_resp_evict", int'(bus.resp_evict_o), 0);

    req(OP_READ, 1, 1);
    chk("t1_hit", int'(bus.resp_hit_o), 0);
    chk("t1_way", int'(bus.resp_way_o), 0);
    chk("t1_state", int'(bus.resp_state_o), 0);
    req(OP_READ, 1, 1);
    chk("t1b_hit", int'(bus.resp_hit_o), 1);
    chk("t1b_state", int'(bus.resp_state_o), 4);

    do_reset();
    req(OP_WRITE, 1, 0);
    for (int t = 2; t <= 8; t++) req(OP_READ, t, 0);
    req(OP_READ, 9, 0);
    chk("t2_hit", int'(bus.resp_hit_o), 0);
    chk("t2_way", int'(bus.resp_way_o), 0);
    chk("t2_state", int'(bus.resp_state_o), 2);
    chk("t2_evict", int'(bus.resp_evict_o), 1);
    chk("t2_evict_tag", int'(bus.resp_evict_tag_o), 1);
    req(OP_READ, 10, 0);
    chk("t2b_way", int'(bus.resp_way_o), 4);
    chk("t2b_evict", int'(bus.resp_evict_o), 0);

    req(OP_WRITE, 5, 1);
    req(OP_INVAL, 5, 0);
    chk("t3_inval_hit", int'(bus.resp_hit_o), 1);
    chk("t3_inval_evict", int'(bus.resp_evict_o), 0);
    req(OP_READ, 5, 0);
    chk("t3_realloc_hit", int'(bus.resp_hit_o), 0);
    chk("t3_realloc_way", int'(bus.resp_way_o), 2);

    do_reset();
    for (int w = 0; w < WAYS; w++)
      req((w == 2 || w == 6) ? OP_WRITE : OP_READ, 20 + w, 0);
    run_walk(3, 0);
    req(OP_FLUSH, 22, 0);
    chk("t4_flush_hit", int'(bus.resp_hit_o), 1);
    chk("t4_flush_evict", int'(bus.resp_evict_o), 0);
    req(OP_FLUSH, 26, 0);
    chk("t4_flush2_evict", int'(bus.resp_evict_o), 0);

    run_walk(0, 1);
    chk("t5_req_dropped", rq.size(), 0);
    req(OP_WRITE, 30, 1);
    void'(m_walk());
    bus.walk_start_i = 1;
    @(posedge clk); #1;
    bus.walk_start_i = 0;
    n = 0;
    while (!bus.wb_valid_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_reach_wb", int'(bus.wb_valid_o), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("t5_rst_wb_valid", int'(bus.wb_valid_o), 0);
    chk("t5_rst_ready", int'(bus.req_ready_o), 1);
    chk("t5_rst_busy", int'(bus.walk_busy_o), 0);
    do_reset();
    req(OP_READ, 30, 1);
    chk("t5_after_rst_hit", int'(bus.resp_hit_o), 0);
    chk("t5_after_rst_state", int'(bus.resp_state_o), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0)
        run_walk(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else
        req(op_e'($urandom_range(0, 3)), int'($urandom_range(1, 12)),
            int'($urandom_range(0, OFFSETS - 1)));
    end

    repeat (3) @(posedge clk);
    chk("resp_queue_drained", rq.size(), 0);
    chk("wb_queue_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
